// File: rtl/bfm_ahbslave_mem_if.sv
// -----------------------------------------------------------------------------
// bfm_ahbslave_mem_if
// AHB-Lite slave-port bundle for the bfm_ahbslave_mem memory model.
//
// Parameters:
//   AWIDTH  HADDR width
//   DWIDTH  data bus width (32 or 64)
//
// Signals (master -> slave):
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
//   HREADYIN
// Signals (slave -> master):
//   HRDATA, HREADYOUT, HRESP
//
// Modports:
//   master  drives the request side (bus fabric / testbench)
//   slave   drives the response side (memory model)
// -----------------------------------------------------------------------------
interface bfm_ahbslave_mem_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
);
  logic              HSEL;
  logic [AWIDTH-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HMASTLOCK;
  logic [DWIDTH-1:0] HWDATA;
  logic              HREADYIN;
  logic [DWIDTH-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
           HWDATA, HREADYIN,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
           HWDATA, HREADYIN,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/bfm_ahbslave_mem.sv
// -----------------------------------------------------------------------------
// bfm_ahbslave_mem
// Parametrised AHB-Lite slave memory model for CPU/DMA testbenches. Supports
// byte-lane writes from HSIZE/HADDR, a run-time wait-state count, a two-cycle
// ERROR response for illegal size/alignment, and saturating OKAY counters.
//
// Optional feature (compile-time macro BFM_AHBSLAVE_ERRWIN_EN):
//   when defined, legal transfers with ERR_BASE <= HADDR < ERR_BASE+ERR_SIZE
//   also receive an ERROR response (no write, no count, no wait states).
//   When undefined, ERR_BASE/ERR_SIZE have no effect.
//
// Ports:
//   HCLK      in   bus clock, rising edge
//   HRESETN   in   asynchronous active-low reset
//   bus       slave modport of bfm_ahbslave_mem_if (AHB-Lite signals)
//   WAITCYC   in   wait states per transfer, sampled at accept, clamped to MAXWAIT
//   WRCOUNT   out  saturating count of OKAY writes
//   RDCOUNT   out  saturating count of OKAY reads
//
// Memory contents are not cleared by reset.
// -----------------------------------------------------------------------------
module bfm_ahbslave_mem #(
  parameter int AWIDTH   = 16,
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 1024,
  parameter int MAXWAIT  = 15,
  parameter int ERR_BASE = 0,
  parameter int ERR_SIZE = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETN,
  bfm_ahbslave_mem_if.slave      bus,
  input  logic [3:0]             WAITCYC,
  output logic [15:0]            WRCOUNT,
  output logic [15:0]            RDCOUNT
);

  localparam int LANES = DWIDTH / 8;
  localparam int LB    = $clog2(LANES);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DWIDTH != 32 && DWIDTH != 64) begin : g_bad_dwidth
    $error("bfm_ahbslave_mem: DWIDTH must be 32 or 64");
  end
  if (ERR_BASE < 0 || ERR_SIZE < 0) begin : g_bad_errwin
    $error("bfm_ahbslave_mem: ERR_BASE/ERR_SIZE must be non-negative");
  end

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Lanes covered by a 2^size-byte transfer starting at byte offset off.
  function automatic logic [LANES-1:0] lane_mask(input logic [2:0] size,
                                                 input logic [LB-1:0] off);
    logic [LANES-1:0] m;
    int lo;
    int n;
    m  = '0;
    lo = int'(off);
    n  = 1 << size;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (i >= lo) && (i < lo + n);
    end
    return m;
  endfunction

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              hready_q;
  logic              hresp_q;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [IW-1:0]     idx_p0;
  logic [LANES-1:0]  be_p0;
  logic              write_p0;

  logic              can_accept;
  logic              accept;
  logic              size_bad;
  logic              align_bad;
  logic              errwin_hit;
  logic              illegal;
  logic [LB-1:0]     size_mask;
  logic [3:0]        w_clamped;
  logic [IW-1:0]     idx_a;
  logic [LANES-1:0]  be_a;

  // ---- address phase: decode and accept ----
  // A new address phase is only taken while the slave is not stalling.
  assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept     = can_accept && bus.HSEL && bus.HREADYIN && bus.HTRANS[1];

  assign size_bad  = bus.HSIZE > 3'(LB);
  // Only meaningful when size is legal; oversized transfers are already illegal.
  assign size_mask = LB'((1 << bus.HSIZE) - 1);
  assign align_bad = |(bus.HADDR[LB-1:0] & size_mask);

`ifdef BFM_AHBSLAVE_ERRWIN_EN
  assign errwin_hit = (64'(bus.HADDR) >= 64'(ERR_BASE)) &&
                      (64'(bus.HADDR) <  64'(ERR_BASE) + 64'(ERR_SIZE));
`else
  assign errwin_hit = 1'b0;
`endif

  assign illegal   = size_bad || align_bad || errwin_hit;
  assign w_clamped = (int'(WAITCYC) > MAXWAIT) ? 4'(MAXWAIT) : WAITCYC;
  // Word index wraps silently modulo DEPTH.
  assign idx_a     = IW'(64'(bus.HADDR >> LB) % 64'(DEPTH));
  assign be_a      = lane_mask(bus.HSIZE, bus.HADDR[LB-1:0]);

  always_ff @(posedge HCLK) begin
    if (accept) begin
      idx_p0   <= idx_a;
      be_p0    <= be_a;
      write_p0 <= bus.HWRITE;
    end
  end

  // ---- control FSM with registered HREADYOUT/HRESP ----
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else if (accept) begin
      if (illegal) begin
        state    <= S_ERR1;
        hready_q <= 1'b0;
        hresp_q  <= 1'b1;
      end else if (w_clamped != 4'd0) begin
        state    <= S_WAIT;
        wait_cnt <= w_clamped;
        hready_q <= 1'b0;
        hresp_q  <= 1'b0;
      end else begin
        state    <= S_DATA;
        hready_q <= 1'b1;
        hresp_q  <= 1'b0;
      end
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state    <= S_DATA;
            hready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state    <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HREADYOUT = hready_q;
  assign bus.HRESP     = hresp_q;

  // ---- data phase: memory access and counters ----
  // A write commits on the DATA edge, so a back-to-back read sees it next cycle.
  always_ff @(posedge HCLK) begin
    if (state == S_DATA && write_p0) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_p0[i]) mem[idx_p0][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HRDATA = (state == S_DATA) ? mem[idx_p0] : '0;

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      WRCOUNT <= '0;
      RDCOUNT <= '0;
    end else if (state == S_DATA) begin
      if (write_p0) WRCOUNT <= sat_inc(WRCOUNT);
      else          RDCOUNT <= sat_inc(RDCOUNT);
    end
  end

  logic unused_bus;
  assign unused_bus = ^{bus.HTRANS[0], bus.HBURST, bus.HPROT, bus.HMASTLOCK};

endmodule
